pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.
//  Detects load-use hazards, issues branch flushes and freezes the pipe on data-memory wait states.
//  Holds a timeout watchdog and saturating stall/flush performance counters.
//  Sits beside the ID/EX register and drives its bubble input; the PC and the other stage registers take their enables from it.
// PARAMETERS
//  ADDR_W    6     register-address width (matches the ID/EX Rs/Rt/Rd fields)
//  TIMEOUT   255   max consecutive memory-wait cycles before error (1..65535)
//  CNT_W     32    perf-counter width
// PORTS
//  clk_i               in   1       clock; all state updates on rising edge
//  rst_n_i             in   1       synchronous, active-low reset
//  if_id_rs_i          in   ADDR_W  Rs of instruction in ID
//  if_id_rt_i          in   ADDR_W  Rt of instruction in ID
//  id_ex_memread_i     in   1       instruction in EX is a load (MEM ctrl bit)
//  id_ex_rt_i          in   ADDR_W  load destination (Rt) in EX
//  branch_taken_i      in   1       branch resolved taken in ID
//  mem_req_i           in   1       EX/MEM instruction accesses data memory
//  mem_ready_i         in   1       data memory completes the access this cycle
//  pc_write_o          out  1       PC load enable
//  if_id_write_o       out  1       IF/ID load enable
//  if_id_flush_o       out  1       IF/ID load a NOP
//  id_ex_write_o       out  1       ID/EX load enable
//  id_ex_bubble_o      out  1       zero WB/MEM/EX controls going into ID/EX
//  ex_mem_write_o      out  1       EX/MEM and MEM/WB load enable
//  mem_err_o           out  1       sticky memory-timeout error
//  stall_cnt_o         out  CNT_W   cycles with pc_write_o=0, saturating
//  flush_cnt_o         out  CNT_W   flushes issued, saturating
// BEHAVIOUR
//  States: RUN, MEM_WAIT, ERR. Reset -> RUN, wait_cnt=0, mem_err_o=0, counters=0.
//  While rst_n_i=0, all *_write_o=0, flush/bubble=0.
//  Outputs are combinational from state + inputs (zero latency); state/counters are registered.
//  RUN:
//   - freeze = mem_req_i & ~mem_ready_i. Drive all *_write_o=0, flush=0, bubble=0; next state MEM_WAIT, wait_cnt=1.
//   - else load_use = id_ex_memread_i & id_ex_rt_i!=0 & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i).
//     Drive pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1, ex_mem_write=1. Stall lasts exactly 1 cycle
//     because the bubble clears memread.
//   - else if branch_taken_i: if_id_flush_o=1, all writes=1, flush_cnt++.
//   - else all writes=1.
//   - Priority: freeze > load_use > branch. A branch is suppressed under load_use; it is re-evaluated next cycle.
//  MEM_WAIT: all writes=0.
//   - mem_ready_i=1 -> RUN, wait_cnt=0. The freeze is released in the same cycle: the RUN decode applies with
//     freeze=0, so the access completes.
//   - wait_cnt==TIMEOUT with ready=0 -> ERR, mem_err_o=1.
//   - otherwise wait_cnt++.
//  ERR: all writes=0, flush=0, bubble=0. Leave only via reset. mem_err_o stays 1.
//  stall_cnt_o increments every cycle pc_write_o=0 with rst_n_i=1 (includes ERR); both counters saturate at all-ones.
//  Reset mid-MEM_WAIT or mid-ERR: next cycle RUN, counters 0, no residual stall.
// STRUCTURE
//  pipe_ctrl_pkg: state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2), ADDR_W/CNT_W defaults, sat_inc function.
//  Sub-module hazard_detect: combinational load-use compare (rs, rt, ex_rt, memread -> load_use).
//  Top: FSM, wait counter, perf counters, output decode.
// TESTING
//  1 Load-use: memread=1, ex_rt=5, rs=5 -> 1 cycle pc_write=0, if_id_write=0, bubble=1; stall_cnt=1.
//  2 r0 load: memread=1, ex_rt=0, rs=0 -> no stall; all writes=1.
//  3 Branch: branch_taken=1 alone -> if_id_flush=1 one cycle, flush_cnt=1.
//    Branch together with load-use -> flush=0, stall=1.
//  4 Mem wait: mem_req=1, ready low for 3 cycles then high -> writes=0 for 3 cycles, RUN on 4th, stall_cnt=3.
//  5 Timeout: TIMEOUT=4, ready never high -> ERR after 4 wait cycles; mem_err_o=1; writes stay 0 until
//    rst_n_i=0, then RUN with counters 0.
//  6 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt_o holds 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller:
// FSM state encoding, default widths and a saturating increment.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned CNT_W_DEF  = 32;

    // Increment v, clamping at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Register 0 never creates a dependency.
module hazard_detect #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic              memread,
    output logic              load_use
);

    always_comb begin
        load_use = memread && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch flushes, data-memory freeze with
// timeout watchdog, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] if_id_rs_i,
    input  logic [ADDR_W-1:0] if_id_rt_i,
    input  logic              id_ex_memread_i,
    input  logic [ADDR_W-1:0] id_ex_rt_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_write_o,
    output logic              id_ex_bubble_o,
    output logic              ex_mem_write_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic [15:0]       wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              load_use;
    logic              freeze;
    logic              run_dec;

    hazard_detect #(
        .ADDR_W (ADDR_W)
    ) u_hazard_detect (
        .rs       (if_id_rs_i),
        .rt       (if_id_rt_i),
        .ex_rt    (id_ex_rt_i),
        .memread  (id_ex_memread_i),
        .load_use (load_use)
    );

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        run_dec        = 1'b0;
        freeze         = mem_req_i && !mem_ready_i;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_write_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_write_o = 1'b0;

        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = MEM_WAIT;
                    wait_d  = 16'd1;
                end else begin
                    run_dec = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Ready releases the freeze in the same cycle, so the normal decode applies here.
                if (mem_ready_i) begin
                    state_d = RUN;
                    wait_d  = '0;
                    run_dec = 1'b1;
                end else if (wait_q == TIMEOUT_L) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ERR: ;
            default: state_d = RUN;
        endcase

        if (run_dec) begin
            if (load_use) begin
                id_ex_write_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
                ex_mem_write_o = 1'b1;
            end else begin
                pc_write_o     = 1'b1;
                if_id_write_o  = 1'b1;
                id_ex_write_o  = 1'b1;
                ex_mem_write_o = 1'b1;
                if_id_flush_o  = branch_taken_i;
            end
        end

        if (!rst_n_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            id_ex_bubble_o = 1'b0;
            ex_mem_write_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!pc_write_o) begin
                stall_q <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
            end
            if (if_id_flush_o) begin
                flush_q <= CNT_W'(sat_inc(64'(flush_q), CNT_W));
            end
        end
    end

    assign mem_err_o   = (state_q == ERR);
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] rs = '0, rt = '0, ex_rt = '0;
    logic              memread = 1'b0, br = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;
    logic              pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model state
    bit         m_wait, m_err;
    int         m_wn, m_stall, m_flush;
    logic [5:0] exp_o;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .if_id_rs_i      (rs),
        .if_id_rt_i      (rt),
        .id_ex_memread_i (memread),
        .id_ex_rt_i      (ex_rt),
        .branch_taken_i  (br),
        .mem_req_i       (mem_req),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .if_id_write_o   (if_id_write),
        .if_id_flush_o   (if_id_flush),
        .id_ex_write_o   (id_ex_write),
        .id_ex_bubble_o  (id_ex_bubble),
        .ex_mem_write_o  (ex_mem_write),
        .mem_err_o       (mem_err),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write}
    function automatic logic [5:0] model_outs();
        bit lu;
        if (!rst_n || m_err) return 6'b000000;
        if (!mem_ready && (m_wait || mem_req)) return 6'b000000;
        lu = memread && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
        if (lu) return 6'b000111;
        return {1'b1, 1'b1, br, 1'b1, 1'b0, 1'b1};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_wait = 0; m_err = 0; m_wn = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_o[5]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (exp_o[3])  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (!m_err) begin
                if (m_wait) begin
                    if (mem_ready) m_wait = 0;
                    else if (m_wn == TIMEOUT) begin m_err = 1; m_wait = 0; end
                    else m_wn++;
                end else if (mem_req && !mem_ready) begin
                    m_wait = 1;
                    m_wn   = 1;
                end
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        exp_o = model_outs();
        chk({tag, "/outs"}, 64'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write}), 64'(exp_o));
        chk({tag, "/stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, "/flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
        chk({tag, "/mem_err"}, 64'(mem_err), 64'(m_err));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        memread = 0; br = 0; mem_req = 0; mem_ready = 1; rs = '0; rt = '0; ex_rt = '0;
    endtask

    initial begin
        m_wait = 0; m_err = 0; m_wn = 0; m_stall = 0; m_flush = 0;

        // Reset with busy inputs: every enable held low
        rst_n = 0; memread = 1; ex_rt = 6'd3; rs = 6'd3; br = 1; mem_req = 1; mem_ready = 0;
        cycle("reset");
        cycle("reset");
        rst_n = 1; idle();
        cycle("idle");

        // Load-use on Rs: single stall cycle
        memread = 1; ex_rt = 6'd5; rs = 6'd5; rt = 6'd7;
        cycle("load_use");
        chk("load_use_stall_cnt", 64'(stall_cnt), 64'd1);
        idle();
        cycle("after_load_use");

        // Load into r0 never stalls
        memread = 1; ex_rt = 6'd0; rs = 6'd0; rt = 6'd0;
        cycle("r0_load");
        idle();

        // Branch alone flushes; branch under load-use is suppressed
        br = 1;
        cycle("branch");
        chk("branch_flush_cnt", 64'(flush_cnt), 64'd1);
        memread = 1; ex_rt = 6'd9; rt = 6'd9;
        cycle("branch_lu");
        idle();
        cycle("idle2");

        // Memory wait: ready low 3 cycles then high
        rst_n = 0;
        cycle("rst2");
        rst_n = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cycle("mem_wait");
        mem_ready = 1;
        cycle("mem_release");
        chk("mem_wait_stall_cnt", 64'(stall_cnt), 64'd3);
        idle();
        cycle("idle3");

        // Timeout into ERR, which holds until reset
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) cycle("timeout");
        chk("timeout_not_yet", 64'(mem_err), 64'd0);
        cycle("timeout_last");
        chk("timeout_err", 64'(mem_err), 64'd1);
        for (int i = 0; i < 3; i++) cycle("err_hold");
        mem_ready = 1; mem_req = 0;
        cycle("err_ready");
        rst_n = 0;
        cycle("err_reset");
        rst_n = 1; idle();
        cycle("post_err");
        chk("post_err_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("post_err_pc_write", 64'(pc_write), 64'd1);

        // Saturation: 20 consecutive load-use stalls on a 4-bit counter
        memread = 1; ex_rt = 6'd12; rt = 6'd12;
        for (int i = 0; i < 20; i++) cycle("saturate");
        chk("stall_saturated", 64'(stall_cnt), 64'd15);
        idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            rs        = ADDR_W'($urandom_range(0, 3));
            rt        = ADDR_W'($urandom_range(0, 3));
            ex_rt     = ADDR_W'($urandom_range(0, 3));
            memread   = ($urandom_range(0, 2) == 0);
            br        = ($urandom_range(0, 3) == 0);
            mem_req   = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 4) != 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
